// File: rtl/riscv_mem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4
  } whb_load_e;

  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2
  } whb_store_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RESP,
    ACK
  } dmem_state_e;

  // Store byte enables; whb 3-7 yield no lanes so the store becomes a no-op.
  function automatic logic [3:0] lane_be(logic [2:0] whb, logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (whb)
      3'(SB):  be = 4'b0001 << off;
      3'(SH):  be = off[1] ? 4'b1100 : 4'b0011;
      3'(SW):  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_data(logic [2:0] whb, logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (whb)
      3'(SB):  d = {4{wdata[7:0]}};
      3'(SH):  d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Select and extend the addressed lane of a RAM word; unknown load codes act as LW.
  function automatic logic [31:0] load_extend(logic [31:0] word, logic [2:0] whb,
                                              logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (whb)
      3'(LB):  r = {{24{b[7]}}, b};
      3'(LH):  r = {{16{h[15]}}, h};
      3'(LBU): r = {24'h000000, b};
      3'(LHU): r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Halfword with odd address, or word with any offset, is misaligned.
  function automatic logic is_misaligned(logic store, logic [2:0] whb, logic [1:0] off);
    logic half;
    logic word;
    if (store) begin
      half = (whb == 3'(SH));
      word = (whb == 3'(SW));
    end else begin
      half = (whb == 3'(LH)) || (whb == 3'(LHU));
      word = !((whb == 3'(LB)) || (whb == 3'(LBU)) || half);
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write and registered read share the single port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against an on-chip word RAM.
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned accesses on rsp_err.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRW,
  input  logic [2:0]  whb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rdata,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  logic [2:0]  whb_q;
  logic [1:0]  off_q;
  logic        mis_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        mis;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // Address bits above the word index alias onto the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign accept = req_valid && (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign mis = is_misaligned(MemRW, whb, addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Stores write at the accept edge; loads issue their read at the same edge.
  assign ram_we    = accept && MemRW && !mis;
  assign ram_be    = lane_be(whb, addr[1:0]);
  assign ram_wdata = store_data(whb, wdata);

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (addr[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // FSM state register; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: store IDLE->ACK->IDLE, load IDLE->RD->RESP->IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MemRW ? ACK : RD;
      RD:      state_d = RESP;
      RESP:    state_d = IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request attributes needed after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      whb_q <= 3'd0;
      off_q <= 2'd0;
      mis_q <= 1'b0;
    end else if (accept) begin
      whb_q <= whb;
      off_q <= addr[1:0];
      mis_q <= mis;
    end
  end

  // Load data is extended out of RD and held; stores present zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (accept && MemRW) begin
      rdata_q <= 32'h0;
    end else if (state_q == RD) begin
      rdata_q <= mis_q ? 32'h0 : load_extend(ram_rdata, whb_q, off_q);
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) || (state_q == ACK);
  assign rdata     = rdata_q;

`ifdef MISALIGN_TRAP_EN
  assign rsp_err = rsp_valid && mis_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model expectations, monitor pops on rsp_valid.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemRW = 1'b0;
  logic [2:0]  whb = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rdata;
  logic        stall;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemRW     (MemRW),
    .whb       (whb),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rdata     (rdata),
    .stall     (stall)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          nissue = 0;
  int          nrsp = 0;
  bit   [31:0] mdl[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: memory as an array of words, lanes by shift/mask arithmetic.
  function automatic exp_t model(bit rw, bit [2:0] w, bit [31:0] a, bit [31:0] d, int now);
    exp_t        r;
    int          idx;
    int          off;
    int          size;
    int          sh;
    bit          mis;
    bit   [31:0] word;
    bit   [31:0] mask;
    bit   [31:0] v;
    idx = int'((a >> 2) % DEPTH);
    off = int'(a % 4);
    if (rw) size = (w == 0) ? 1 : (w == 1) ? 2 : (w == 2) ? 4 : 0;
    else    size = (w == 0 || w == 3) ? 1 : (w == 1 || w == 4) ? 2 : 4;
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
`endif
    r.err   = mis;
    r.rdata = 32'h0;
    r.cyc   = now + (rw ? 1 : 2);
    word = mdl.exists(idx) ? mdl[idx] : 32'h0;
    if (rw) begin
      if (!mis && size != 0) begin
        if (size == 1) begin
          sh   = 8 * off;
          mask = 32'hFF << sh;
          word = (word & ~mask) | ((d & 32'hFF) << sh);
        end else if (size == 2) begin
          sh   = 16 * (off / 2);
          mask = 32'hFFFF << sh;
          word = (word & ~mask) | ((d & 32'hFFFF) << sh);
        end else begin
          word = d;
        end
        mdl[idx] = word;
      end
    end else if (!mis) begin
      if (size == 1) begin
        v = (word >> (8 * off)) & 32'hFF;
        if (w == 0 && v >= 128) v = v - 256;
      end else if (size == 2) begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (w == 1 && v >= 32768) v = v - 65536;
      end else begin
        v = word;
      end
      r.rdata = v;
    end
    return r;
  endfunction

  // Present one request at the first IDLE cycle; keep leaves req_valid asserted afterwards.
  task automatic issue(input bit rw, input bit [2:0] w, input bit [31:0] a, input bit [31:0] d,
                       input bit keep, input bit track);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    req_valid = 1'b1;
    MemRW     = rw;
    whb       = w;
    addr      = a;
    wdata     = d;
    e = model(rw, w, a, d, cyc);
    if (track) begin
      sb.push_back(e);
      nissue++;
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  // Monitor: handshake invariants every cycle, scoreboard pop on each response.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall_vs_ready", 32'(stall), 32'(!req_ready));
      if (!rsp_valid) chk("err_without_valid", 32'(rsp_err), 32'h0);
      if (rsp_valid) begin
        nrsp++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=rsp_valid required=no_response (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_rdata", rdata, mon_e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp_latency_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  initial begin
    int n;
    bit [31:0] a;
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;

    // Give the model a defined image of the words used below.
    for (int i = 0; i < 16; i++) issue(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0, 1'b1);

    // Reset in RD: the load must never respond.
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'h1);
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst_req_ready", 32'(req_ready), 32'h1);
    chk("postrst_stall", 32'(stall), 32'h0);

    // Lane extraction around a known word.
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 3'd3, 32'h13, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 3'd0, 32'h11, 32'h55, 1'b0, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 3'd1, 32'h10, 32'h1234, 1'b0, 1'b1);
    issue(1'b0, 3'd4, 32'h10, 32'h0, 1'b0, 1'b1);
    // Unsupported store code and load code 5-7.
    issue(1'b1, 3'd5, 32'h10, 32'hFFFFFFFF, 1'b0, 1'b1);
    issue(1'b0, 3'd7, 32'h10, 32'h0, 1'b0, 1'b1);

    // Aliasing above the word index.
    issue(1'b1, 3'd2, 32'(DEPTH * 4 + 32'h20), 32'hA5A5A5A5, 1'b0, 1'b1);
    issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1);

    // Misaligned word access, load and store, then readback of the aligned word.
    issue(1'b0, 3'd2, 32'h12, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 3'd2, 32'h12, 32'h01020304, 1'b0, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 3'd1, 32'h11, 32'h0, 1'b0, 1'b1);

    // req_valid held high across back-to-back accesses.
    for (int i = 0; i < 8; i++)
      issue(1'(i % 2), 3'(i % 3), 32'(32 + 4 * (i % 4) + (i % 2)), $urandom, (i != 7), 1'b1);

    // Randomized traffic over the initialised words with random alias bits.
    for (int i = 0; i < 150; i++) begin
      a = ($urandom << (AW + 2)) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            (i != 149) && ($urandom_range(0, 1) == 1), 1'b1);
    end

    // Drain outstanding expectations.
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", 32'(sb.size()), 32'h0);
    chk("response_count", 32'(nrsp), 32'(nissue));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
